// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and IF/ID register.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'hD503201F;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic {S_RUN, S_HALT} fetch_state_t;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Control inputs, instruction-memory port and IF/ID outputs of the fetch stage.
interface if_id_fetch_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               halt_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;

    modport master (
        input  stall, br_taken, br_target, halt_req, imem_rdata,
        output imem_addr, id_pc, id_instr, id_valid
    );

    modport slave (
        output stall, br_taken, br_target, halt_req, imem_rdata,
        input  imem_addr, id_pc, id_instr, id_valid
    );
endinterface

// File: rtl/if_id_fetch_stage_regs.sv
// Building blocks for the fetch stage: load-enable register and saturating counter.
module en_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end
endmodule

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    // Sticks at all-ones so a long run never reads back as a small value.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC, IF/ID register, stall/redirect/halt handling, perf counters.
module if_id_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    if_id_fetch_stage_if.master bus,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_cnt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);
    fetch_state_t       state_q, state_d;
    logic               pc_en, id_en, bubble;
    logic               fetch_inc, stall_inc, bubble_inc;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  id_pc_d;
    logic [INSTR_W-1:0] id_instr_d;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    // Priority in S_RUN: halt_req, then br_taken, then stall, then normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        id_en      = 1'b0;
        bubble     = 1'b0;
        fetch_inc  = 1'b0;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (state_q == S_RUN) begin
            if (bus.halt_req) begin
                state_d    = S_HALT;
                id_en      = 1'b1;
                bubble     = 1'b1;
                bubble_inc = 1'b1;
            end else if (bus.br_taken) begin
                pc_en      = 1'b1;
                id_en      = 1'b1;
                bubble     = 1'b1;
                bubble_inc = 1'b1;
            end else if (bus.stall) begin
                stall_inc  = 1'b1;
            end else begin
                pc_en      = 1'b1;
                id_en      = 1'b1;
                fetch_inc  = 1'b1;
            end
        end
    end

    // Redirect targets are forced onto an instruction boundary.
    assign pc_d = bus.br_taken ? (bus.br_target & ~ADDR_W'(INSTR_BYTES - 1))
                               : pc_q + ADDR_W'(INSTR_BYTES);

    assign id_pc_d    = bubble ? '0 : pc_q;
    assign id_instr_d = bubble ? INSTR_W'(NOP_INSTR) : bus.imem_rdata;

    assign bus.imem_addr = pc_q;
    assign halted        = (state_q == S_HALT);

    en_register #(.WIDTH(ADDR_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q)
    );

    en_register #(.WIDTH(ADDR_W), .RESET_VAL('0)) u_id_pc (
        .clk(clk), .reset(reset), .en(id_en), .d(id_pc_d), .q(bus.id_pc)
    );

    en_register #(.WIDTH(INSTR_W), .RESET_VAL(INSTR_W'(NOP_INSTR))) u_id_instr (
        .clk(clk), .reset(reset), .en(id_en), .d(id_instr_d), .q(bus.id_instr)
    );

    en_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_id_valid (
        .clk(clk), .reset(reset), .en(id_en), .d(~bubble), .q(bus.id_valid)
    );

    sat_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
        .clk(clk), .reset(reset), .inc(fetch_inc), .count(fetch_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .count(stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk(clk), .reset(reset), .inc(bubble_inc), .count(bubble_cnt)
    );
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Two fetch stages (default and wrap/4-bit-counter variants) checked against a behavioural model.
module tb_if_id_fetch_stage;
    import fetch_pkg::*;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        t_reset, t_stall, t_br, t_halt;
    logic [63:0] t_tgt;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    logic        halted_a, halted_b;
    logic [31:0] fetch_a, stall_a, bubble_a;
    logic [3:0]  fetch_b, stall_b, bubble_b;

    // Model state, index 0 = default DUT, index 1 = wrap/saturation DUT
    logic [63:0] m_pc[2];
    logic [63:0] m_id_pc[2];
    logic [31:0] m_instr[2];
    logic        m_valid[2];
    logic        m_halt[2];
    longint      m_fc[2], m_sc[2], m_bc[2];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] + 32'hA000;
    endfunction

    if_id_fetch_stage_if #(.ADDR_W(64), .INSTR_W(32)) bus_a ();
    if_id_fetch_stage_if #(.ADDR_W(64), .INSTR_W(32)) bus_b ();

    assign bus_a.stall      = t_stall;
    assign bus_a.br_taken   = t_br;
    assign bus_a.br_target  = t_tgt;
    assign bus_a.halt_req   = t_halt;
    assign bus_a.imem_rdata = mem_word(bus_a.imem_addr);
    assign bus_b.stall      = t_stall;
    assign bus_b.br_taken   = t_br;
    assign bus_b.br_target  = t_tgt;
    assign bus_b.halt_req   = t_halt;
    assign bus_b.imem_rdata = mem_word(bus_b.imem_addr);

    if_id_fetch_stage dut (
        .clk(clk), .reset(t_reset), .bus(bus_a), .halted(halted_a),
        .fetch_cnt(fetch_a), .stall_cnt(stall_a), .bubble_cnt(bubble_a)
    );

    if_id_fetch_stage #(.RESET_PC(WRAP_PC), .CNT_W(4)) dut_b (
        .clk(clk), .reset(t_reset), .bus(bus_b), .halted(halted_b),
        .fetch_cnt(fetch_b), .stall_cnt(stall_b), .bubble_cnt(bubble_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            longint maxv = (k == 0) ? 64'hFFFF_FFFF : 15;
            if (t_reset) begin
                m_pc[k]    = (k == 0) ? 64'd0 : WRAP_PC;
                m_id_pc[k] = '0;
                m_instr[k] = NOP_INSTR;
                m_valid[k] = 1'b0;
                m_halt[k]  = 1'b0;
                m_fc[k] = 0; m_sc[k] = 0; m_bc[k] = 0;
            end else if (!m_halt[k]) begin
                if (t_halt || t_br) begin
                    m_id_pc[k] = '0;
                    m_instr[k] = NOP_INSTR;
                    m_valid[k] = 1'b0;
                    m_bc[k]    = sat_inc(m_bc[k], maxv);
                    if (t_halt) m_halt[k] = 1'b1;
                    else        m_pc[k]   = (t_tgt / 4) * 4;
                end else if (t_stall) begin
                    m_sc[k] = sat_inc(m_sc[k], maxv);
                end else begin
                    m_id_pc[k] = m_pc[k];
                    m_instr[k] = mem_word(m_pc[k]);
                    m_valid[k] = 1'b1;
                    m_pc[k]    = m_pc[k] + 64'd4;
                    m_fc[k]    = sat_inc(m_fc[k], maxv);
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("a_addr",   bus_a.imem_addr, m_pc[0]);
        checkOutput("a_id_pc",  bus_a.id_pc, m_id_pc[0]);
        checkOutput("a_instr",  64'(bus_a.id_instr), 64'(m_instr[0]));
        checkOutput("a_valid",  64'(bus_a.id_valid), 64'(m_valid[0]));
        checkOutput("a_halted", 64'(halted_a), 64'(m_halt[0]));
        checkOutput("a_fetch",  64'(fetch_a), m_fc[0]);
        checkOutput("a_stall",  64'(stall_a), m_sc[0]);
        checkOutput("a_bubble", 64'(bubble_a), m_bc[0]);
        checkOutput("b_addr",   bus_b.imem_addr, m_pc[1]);
        checkOutput("b_id_pc",  bus_b.id_pc, m_id_pc[1]);
        checkOutput("b_instr",  64'(bus_b.id_instr), 64'(m_instr[1]));
        checkOutput("b_valid",  64'(bus_b.id_valid), 64'(m_valid[1]));
        checkOutput("b_halted", 64'(halted_b), 64'(m_halt[1]));
        checkOutput("b_fetch",  64'(fetch_b), m_fc[1]);
        checkOutput("b_stall",  64'(stall_b), m_sc[1]);
        checkOutput("b_bubble", 64'(bubble_b), m_bc[1]);
    endtask

    // Drives one cycle of inputs, advances the model at the edge, checks #1 later.
    task automatic applyStimulus(input logic rst, input logic s, input logic bt,
                                 input logic [63:0] tgt, input logic h);
        t_reset = rst; t_stall = s; t_br = bt; t_tgt = tgt; t_halt = h;
        @(posedge clk);
        modelStep();
        cyc++;
        #1;
        compareAll();
    endtask

    initial begin
        t_reset = 1'b1; t_stall = 1'b0; t_br = 1'b0; t_tgt = '0; t_halt = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_instr", 64'(bus_a.id_instr), 64'h0000_0000_D503_201F);
        checkOutput("rst_b_addr", bus_b.imem_addr, WRAP_PC);

        // Free run, including the wrapping RESET_PC variant
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_addr", bus_b.imem_addr, 64'd0);
        checkOutput("wrap_id_pc", bus_b.id_pc, WRAP_PC);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_fetch", 64'(fetch_a), 64'd4);
        checkOutput("t1_id_pc", bus_a.id_pc, 64'hC);
        checkOutput("t1_instr", 64'(bus_a.id_instr), 64'hA00C);

        // Stall at pc 0x10
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_addr", bus_a.imem_addr, 64'h10);
        checkOutput("t2_stall", 64'(stall_a), 64'd2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_id_pc", bus_a.id_pc, 64'h10);

        // Branch with simultaneous stall
        applyStimulus(0, 1, 1, 64'h103, 0);
        checkOutput("t3_addr", bus_a.imem_addr, 64'h100);
        checkOutput("t3_valid", 64'(bus_a.id_valid), 64'd0);
        checkOutput("t3_bubble", 64'(bubble_a), 64'd1);

        // Counter saturation on the 4-bit variant and mid-run reset
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_sat", 64'(fetch_b), 64'd15);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_clear", 64'(fetch_b), 64'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);

        // Halt at pc 0x20, then ignored control pulses
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 64'h400, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_halted", 64'(halted_a), 64'd1);
        checkOutput("t4_addr", bus_a.imem_addr, 64'h20);
        checkOutput("t4_valid", 64'(bus_a.id_valid), 64'd0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t4_rst_halt", 64'(halted_a), 64'd0);
        checkOutput("t4_rst_addr", bus_a.imem_addr, 64'd0);

        // Randomized mix
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(99) < 2), ($urandom_range(99) < 30),
                          ($urandom_range(99) < 10), {$urandom, $urandom},
                          ($urandom_range(199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
